// File: rtl/core_types.sv
// Shared types for the memory-stage load/store unit: op encoding, FSM states, ALE code.
package core_types;

    typedef enum logic [3:0] {
        OpNone,
        OpLdB,
        OpLdBu,
        OpLdH,
        OpLdHu,
        OpLdW,
        OpStB,
        OpStH,
        OpStW,
        OpLl,
        OpSc
    } lsu_op_t;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StDone,
        StDrain
    } lsu_state_t;

    localparam logic [9:0] ExcpAle = 10'h009;

    function automatic logic is_store(lsu_op_t op);
        return op inside {OpStB, OpStH, OpStW, OpSc};
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane select, store-data replication, load extract/extend and misalignment check.
module lsu_lane_align
    import core_types::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned BYTES = DATA_WIDTH / 8,
    localparam int unsigned OFS = $clog2(BYTES)
) (
    input  lsu_op_t               op,
    input  logic [OFS-1:0]        lane,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [BYTES-1:0]      sel,
    output logic [DATA_WIDTH-1:0] wdata_rep,
    output logic [31:0]           ld_data,
    output logic                  misaligned
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [BYTES-1:0]      sel_b;
    logic [BYTES-1:0]      sel_h;
    logic [BYTES-1:0]      sel_w;
    logic                  unused_bits;

    assign shifted = rdata >> {lane, 3'b000};
    assign sel_b   = BYTES'(1) << lane;
    assign sel_h   = BYTES'(3) << lane;
    assign sel_w   = BYTES'(4'hF) << lane;
    // Only the low word of the store data and of the shifted line is meaningful.
    assign unused_bits = ^{shifted, wdata};

    always_comb begin
        sel        = '0;
        wdata_rep  = '0;
        ld_data    = '0;
        misaligned = 1'b0;
        case (op)
            OpLdB, OpLdBu, OpStB: begin
                sel       = sel_b;
                wdata_rep = {BYTES{wdata[7:0]}};
            end
            OpLdH, OpLdHu, OpStH: begin
                sel        = sel_h;
                wdata_rep  = {(BYTES / 2){wdata[15:0]}};
                misaligned = lane[0];
            end
            OpLdW, OpStW, OpLl, OpSc: begin
                sel        = sel_w;
                wdata_rep  = {(BYTES / 4){wdata[31:0]}};
                misaligned = |lane[1:0];
            end
            default: ;
        endcase
        case (op)
            OpLdB:       ld_data = {{24{shifted[7]}}, shifted[7:0]};
            OpLdBu:      ld_data = {24'd0, shifted[7:0]};
            OpLdH:       ld_data = {{16{shifted[15]}}, shifted[15:0]};
            OpLdHu:      ld_data = {16'd0, shifted[15:0]};
            OpLdW, OpLl: ld_data = shifted[31:0];
            default:     ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu_fsm.sv
// Memory-stage load/store unit: D-cache handshake FSM, LL/SC bit, flush drain, registered WB result.
// Optional MEM_LSU_DIFFTEST_EN adds registered load/store trace outputs.
module mem_lsu_fsm
    import core_types::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter logic [9:0]  ALE_CODE   = ExcpAle,
    localparam int unsigned BYTES = DATA_WIDTH / 8,
    localparam int unsigned OFS = $clog2(BYTES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  llbit_clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  lsu_op_t               in_op,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic                  in_wreg,
    input  logic [REG_ADDR_W-1:0] in_waddr,
    output logic                  req_valid,
    output logic                  req_we,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [BYTES-1:0]      req_sel,
    output logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  addr_ok,
    input  logic                  data_ok,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_wreg,
    output logic [REG_ADDR_W-1:0] out_waddr,
    output logic [31:0]           out_wdata,
    output logic                  out_excp,
    output logic [9:0]            out_excp_num,
`ifdef MEM_LSU_DIFFTEST_EN
    output logic [7:0]            out_ld_en,
    output logic [7:0]            out_st_en,
    output logic [ADDR_WIDTH-1:0] out_ld_addr,
    output logic [ADDR_WIDTH-1:0] out_st_addr,
    output logic [DATA_WIDTH-1:0] out_st_data,
`endif
    output logic                  llbit_o
);

    lsu_state_t            state_q, state_d;
    lsu_op_t               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wreg_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic                  llbit_q, llbit_d;

    logic                  out_wreg_q;
    logic [REG_ADDR_W-1:0] out_waddr_q;
    logic [31:0]           out_wdata_q;
    logic                  out_excp_q;

    logic                  res_load;
    logic                  res_wreg;
    logic [REG_ADDR_W-1:0] res_waddr;
    logic [31:0]           res_wdata;
    logic                  res_excp;

    logic                  idle_like;
    logic                  accept;
    logic                  direct;
    logic                  resp_done;

    lsu_op_t               al_op;
    logic [OFS-1:0]        al_lane;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [BYTES-1:0]      al_sel;
    logic [DATA_WIDTH-1:0] al_wdata_rep;
    logic [31:0]           al_ld_data;
    logic                  al_misaligned;

    // Accept happens only in IDLE/DONE, response only in REQ/RESP, so one aligner serves both.
    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign al_op     = idle_like ? in_op : op_q;
    assign al_lane   = idle_like ? in_addr[OFS-1:0] : addr_q[OFS-1:0];
    assign al_wdata  = idle_like ? in_wdata : wdata_q;

    lsu_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .op        (al_op),
        .lane      (al_lane),
        .wdata     (al_wdata),
        .rdata     (rdata),
        .sel       (al_sel),
        .wdata_rep (al_wdata_rep),
        .ld_data   (al_ld_data),
        .misaligned(al_misaligned)
    );

    assign in_ready  = !rst && ((state_q == StIdle) || (state_q == StDone && out_ready));
    assign accept    = in_valid && in_ready && !flush;
    assign direct    = (in_op == OpNone) || al_misaligned || (in_op == OpSc && !llbit_q);
    assign resp_done = !flush && ((state_q == StReq && addr_ok && data_ok) ||
                                  (state_q == StResp && data_ok));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = direct ? StDone : StReq;
            StReq: begin
                if (flush) state_d = (addr_ok && !data_ok) ? StDrain : StIdle;
                else if (addr_ok) state_d = data_ok ? StDone : StResp;
            end
            StResp: begin
                if (flush) state_d = data_ok ? StIdle : StDrain;
                else if (data_ok) state_d = StDone;
            end
            StDone: begin
                if (flush) state_d = StIdle;
                else if (out_ready) state_d = accept ? (direct ? StDone : StReq) : StIdle;
            end
            StDrain: if (data_ok) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res_load  = 1'b0;
        res_wreg  = 1'b0;
        res_waddr = '0;
        res_wdata = '0;
        res_excp  = 1'b0;
        if (accept && direct) begin
            res_load  = 1'b1;
            res_wreg  = in_wreg && !al_misaligned;
            res_waddr = in_waddr;
            res_wdata = (in_op == OpNone) ? in_wdata[31:0] : 32'd0;
            res_excp  = al_misaligned;
        end else if (resp_done) begin
            res_load  = 1'b1;
            res_wreg  = wreg_q;
            res_waddr = waddr_q;
            if (op_q == OpSc) res_wdata = 32'd1;
            else if (!is_store(op_q)) res_wdata = al_ld_data;
        end
    end

    always_comb begin
        llbit_d = llbit_q;
        if (resp_done && op_q == OpLl) llbit_d = 1'b1;
        if (resp_done && op_q == OpSc) llbit_d = 1'b0;
        if (llbit_clr) llbit_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpNone;
            addr_q      <= '0;
            wdata_q     <= '0;
            wreg_q      <= 1'b0;
            waddr_q     <= '0;
            llbit_q     <= 1'b0;
            out_wreg_q  <= 1'b0;
            out_waddr_q <= '0;
            out_wdata_q <= '0;
            out_excp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            llbit_q <= llbit_d;
            if (accept) begin
                op_q    <= in_op;
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                wreg_q  <= in_wreg;
                waddr_q <= in_waddr;
            end
            if (res_load) begin
                out_wreg_q  <= res_wreg;
                out_waddr_q <= res_waddr;
                out_wdata_q <= res_wdata;
                out_excp_q  <= res_excp;
            end
        end
    end

    assign req_valid    = (state_q == StReq);
    assign req_we       = req_valid && is_store(op_q);
    assign req_addr     = req_valid ? addr_q : '0;
    assign req_sel      = req_valid ? al_sel : '0;
    assign req_wdata    = req_valid ? al_wdata_rep : '0;
    assign out_valid    = (state_q == StDone);
    assign out_wreg     = out_wreg_q;
    assign out_waddr    = out_waddr_q;
    assign out_wdata    = out_wdata_q;
    assign out_excp     = out_excp_q;
    assign out_excp_num = out_excp_q ? ALE_CODE : 10'd0;
    assign llbit_o      = llbit_q;

`ifdef MEM_LSU_DIFFTEST_EN
    logic [7:0]            dt_ld_en_q, dt_st_en_q;
    logic [ADDR_WIDTH-1:0] dt_ld_addr_q, dt_st_addr_q;
    logic [DATA_WIDTH-1:0] dt_st_data_q;
    logic [DATA_WIDTH-1:0] dt_mask;

    for (genvar i = 0; i < int'(BYTES); i++) begin : g_mask
        assign dt_mask[i*8 +: 8] = {8{al_sel[i]}};
    end

    // Trace bits are only set for accesses that actually reached the cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_ld_en_q   <= '0;
            dt_st_en_q   <= '0;
            dt_ld_addr_q <= '0;
            dt_st_addr_q <= '0;
            dt_st_data_q <= '0;
        end else if (res_load) begin
            dt_ld_en_q   <= resp_done ? {2'b00, op_q == OpLl, op_q == OpLdW, op_q == OpLdHu,
                                         op_q == OpLdH, op_q == OpLdBu, op_q == OpLdB} : 8'd0;
            dt_st_en_q   <= resp_done ? {4'b0000, op_q == OpSc, op_q == OpStW, op_q == OpStH,
                                         op_q == OpStB} : 8'd0;
            dt_ld_addr_q <= addr_q;
            dt_st_addr_q <= addr_q;
            dt_st_data_q <= al_wdata_rep & dt_mask;
        end
    end

    assign out_ld_en   = dt_ld_en_q;
    assign out_st_en   = dt_st_en_q;
    assign out_ld_addr = dt_ld_addr_q;
    assign out_st_addr = dt_st_addr_q;
    assign out_st_data = dt_st_data_q;
`endif

endmodule

// File: tb/tb_mem_lsu_fsm.sv
// Directed self-checking bench for mem_lsu_fsm (32-bit and 64-bit data instances).
module tb_mem_lsu_fsm;
    import core_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, llbit_clr, in_valid, in_ready, in_wreg;
    lsu_op_t     in_op;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_waddr;
    logic        req_valid, req_we, addr_ok, data_ok;
    logic [31:0] req_addr, req_wdata, rdata;
    logic [3:0]  req_sel;
    logic        out_valid, out_ready, out_wreg, out_excp, llbit;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;
    logic [9:0]  out_excp_num;

    logic        w_flush, w_llbit_clr, w_in_valid, w_in_ready, w_in_wreg;
    lsu_op_t     w_in_op;
    logic [31:0] w_in_addr, w_req_addr;
    logic [63:0] w_in_wdata, w_req_wdata, w_rdata;
    logic [4:0]  w_in_waddr, w_out_waddr;
    logic        w_req_valid, w_req_we, w_addr_ok, w_data_ok;
    logic [7:0]  w_req_sel;
    logic        w_out_valid, w_out_ready, w_out_wreg, w_out_excp, w_llbit;
    logic [31:0] w_out_wdata;
    logic [9:0]  w_out_excp_num;

    int n_checks = 0;
    int n_errors = 0;
    int n_req = 0;
    int req_base;

    always #5 clk = ~clk;

    always @(posedge clk) if (req_valid && addr_ok) n_req++;

    mem_lsu_fsm #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .llbit_clr(llbit_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_wreg(in_wreg), .in_waddr(in_waddr),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_sel(req_sel),
        .req_wdata(req_wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_wreg(out_wreg),
        .out_waddr(out_waddr), .out_wdata(out_wdata), .out_excp(out_excp),
        .out_excp_num(out_excp_num), .llbit_o(llbit)
    );

    mem_lsu_fsm #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .flush(w_flush), .llbit_clr(w_llbit_clr),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_op(w_in_op), .in_addr(w_in_addr),
        .in_wdata(w_in_wdata), .in_wreg(w_in_wreg), .in_waddr(w_in_waddr),
        .req_valid(w_req_valid), .req_we(w_req_we), .req_addr(w_req_addr),
        .req_sel(w_req_sel), .req_wdata(w_req_wdata), .addr_ok(w_addr_ok),
        .data_ok(w_data_ok), .rdata(w_rdata), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_wreg(w_out_wreg), .out_waddr(w_out_waddr),
        .out_wdata(w_out_wdata), .out_excp(w_out_excp), .out_excp_num(w_out_excp_num),
        .llbit_o(w_llbit)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic wreg, input logic [4:0] waddr);
        in_op    = op;
        in_addr  = addr;
        in_wdata = wd;
        in_wreg  = wreg;
        in_waddr = waddr;
        in_valid = 1'b1;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 0; llbit_clr = 0; in_valid = 0; in_op = OpNone;
        in_addr = 0; in_wdata = 0; in_wreg = 0; in_waddr = 0;
        addr_ok = 0; data_ok = 0; rdata = 0; out_ready = 0;
        w_flush = 0; w_llbit_clr = 0; w_in_valid = 0; w_in_op = OpNone; w_in_addr = 0;
        w_in_wdata = 0; w_in_wreg = 0; w_in_waddr = 0; w_addr_ok = 0; w_data_ok = 0;
        w_rdata = 0; w_out_ready = 0;

        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_llbit", llbit, 0);
        check("rst_out_wdata", out_wdata, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // LD_B 0x1003, hit in REQ cycle
        issue(OpLdB, 32'h1003, 0, 1, 5'd3);
        tick();
        in_valid = 0; addr_ok = 1; data_ok = 1; rdata = 32'h8012_3456;
        #1;
        check("ldb_req_valid", req_valid, 1);
        check("ldb_req_sel", req_sel, 4'b1000);
        check("ldb_req_we", req_we, 0);
        check("ldb_req_addr", req_addr, 32'h1003);
        check("ldb_early_valid", out_valid, 0);
        tick();
        addr_ok = 0; data_ok = 0;
        #1;
        check("ldb_out_valid", out_valid, 1);
        check("ldb_out_wdata", out_wdata, 32'hFFFF_FF80);
        check("ldb_out_wreg", out_wreg, 1);
        check("ldb_out_waddr", out_waddr, 3);
        check("ldb_out_excp", out_excp, 0);
        retire();
        check("ldb_retired", out_valid, 0);

        // ST_H 0x2002, addr_ok cycle 1, data_ok cycle 3
        req_base = n_req;
        issue(OpStH, 32'h2002, 32'h0000_BEEF, 0, 0);
        tick();
        in_valid = 0; addr_ok = 1;
        #1;
        check("sth_req_we", req_we, 1);
        check("sth_req_sel", req_sel, 4'b1100);
        check("sth_req_wdata", req_wdata, 32'hBEEF_BEEF);
        tick();
        addr_ok = 0;
        #1;
        check("sth_resp_no_req", req_valid, 0);
        tick();
        data_ok = 1;
        #1;
        check("sth_resp_no_out", out_valid, 0);
        tick();
        data_ok = 0;
        #1;
        check("sth_out_valid", out_valid, 1);
        check("sth_one_req", n_req - req_base, 1);
        retire();

        // LD_W misaligned
        issue(OpLdW, 32'h3001, 0, 1, 5'd4);
        tick();
        in_valid = 0;
        #1;
        check("ale_no_req", req_valid, 0);
        check("ale_out_valid", out_valid, 1);
        check("ale_excp", out_excp, 1);
        check("ale_excp_num", out_excp_num, 10'h009);
        check("ale_wreg", out_wreg, 0);
        retire();

        // LL then SC (success) then back-to-back SC (fail)
        issue(OpLl, 32'h4000, 0, 1, 5'd6);
        tick();
        in_valid = 0; addr_ok = 1; data_ok = 1; rdata = 32'h1122_3344;
        #1;
        check("ll_req_valid", req_valid, 1);
        tick();
        addr_ok = 0; data_ok = 0;
        #1;
        check("ll_llbit", llbit, 1);
        check("ll_wdata", out_wdata, 32'h1122_3344);
        retire();
        issue(OpSc, 32'h4000, 32'd7, 1, 5'd7);
        tick();
        in_valid = 0; addr_ok = 1; data_ok = 1;
        #1;
        check("sc_req_valid", req_valid, 1);
        check("sc_req_we", req_we, 1);
        check("sc_req_wdata", req_wdata, 32'd7);
        tick();
        addr_ok = 0; data_ok = 0;
        #1;
        check("sc_out_valid", out_valid, 1);
        check("sc_out_wdata", out_wdata, 1);
        check("sc_llbit", llbit, 0);
        out_ready = 1;
        issue(OpSc, 32'h4000, 32'd7, 1, 5'd7);
        #1;
        check("b2b_in_ready", in_ready, 1);
        tick();
        in_valid = 0; out_ready = 0;
        #1;
        check("sc2_out_valid", out_valid, 1);
        check("sc2_no_req", req_valid, 0);
        check("sc2_out_wdata", out_wdata, 0);
        check("sc2_out_wreg", out_wreg, 1);
        retire();

        // LL completing together with llbit_clr: clear wins
        issue(OpLl, 32'h4000, 0, 1, 5'd6);
        tick();
        in_valid = 0; addr_ok = 1; data_ok = 1; llbit_clr = 1;
        tick();
        addr_ok = 0; data_ok = 0; llbit_clr = 0;
        #1;
        check("llclr_llbit", llbit, 0);
        check("llclr_out_valid", out_valid, 1);
        retire();

        // LD_W flushed in RESP, data_ok two cycles later -> DRAIN
        issue(OpLdW, 32'h5000, 0, 1, 5'd8);
        tick();
        in_valid = 0; addr_ok = 1;
        tick();
        addr_ok = 0; flush = 1;
        tick();
        flush = 0;
        issue(OpNone, 32'h0, 32'hCAFE_F00D, 1, 5'd9);
        #1;
        check("drain_in_ready", in_ready, 0);
        check("drain_out_valid", out_valid, 0);
        tick();
        data_ok = 1; rdata = 32'hDEAD_BEEF;
        #1;
        check("drain_in_ready2", in_ready, 0);
        tick();
        data_ok = 0;
        #1;
        check("drain_done_in_ready", in_ready, 1);
        check("drain_done_out_valid", out_valid, 0);
        tick();
        in_valid = 0;
        #1;
        check("none_out_valid", out_valid, 1);
        check("none_out_wdata", out_wdata, 32'hCAFE_F00D);
        check("none_out_waddr", out_waddr, 9);
        retire();

        // Flush in REQ before addr_ok
        req_base = n_req;
        issue(OpLdW, 32'h6000, 0, 1, 5'd2);
        tick();
        in_valid = 0; flush = 1;
        #1;
        check("freq_req_held", req_valid, 1);
        tick();
        flush = 0;
        #1;
        check("freq_req_dropped", req_valid, 0);
        check("freq_in_ready", in_ready, 1);
        check("freq_out_valid", out_valid, 0);
        check("freq_no_handshake", n_req - req_base, 0);

        // Reset mid-operation
        issue(OpLdW, 32'h7000, 0, 1, 5'd2);
        tick();
        in_valid = 0;
        #1;
        check("rstmid_req", req_valid, 1);
        rst = 1;
        #1;
        check("rstmid_req_drop", req_valid, 0);
        check("rstmid_in_ready", in_ready, 0);
        tick();
        rst = 0;
        #1;
        check("rstmid_recover", in_ready, 1);

        // 64-bit: LD_HU at lane 6, WB stalls for three cycles
        w_in_op = OpLdHu; w_in_addr = 32'h1006; w_in_wreg = 1; w_in_waddr = 5'd1;
        w_in_valid = 1;
        tick();
        w_in_valid = 0; w_addr_ok = 1; w_data_ok = 1; w_rdata = 64'h8001_0000_0000_0000;
        #1;
        check("w64_req_sel", w_req_sel, 8'hC0);
        tick();
        w_addr_ok = 0; w_data_ok = 0;
        #1;
        check("w64_out_valid", w_out_valid, 1);
        check("w64_out_wdata", w_out_wdata, 32'h0000_8001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("w64_hold_valid", w_out_valid, 1);
            check("w64_hold_wdata", w_out_wdata, 32'h0000_8001);
        end
        w_out_ready = 1;
        tick();
        w_out_ready = 0;
        #1;
        check("w64_retired", w_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
